// File: rtl/pattern_serializer_101_pkg.sv
// Shared definitions for the pattern serializer and any bench or detector that
// consumes its serial stream.
package pattern_serializer_101_pkg;
   localparam int unsigned DEFAULT_WIDTH = 8;
   localparam int unsigned CNT_W         = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;
endpackage

// File: rtl/pattern_serializer_101_match101_tracker.sv
// Counts overlapping "101" occurrences in the bits emitted within one frame.
// History is cleared on clr so that matches never span two frames.
module match101_tracker
   import pattern_serializer_101_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             bit_i,
   output logic [CNT_W-1:0] count_o
);

   logic [1:0]       hist_q, hist_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       hist_base_s;
   logic [CNT_W-1:0] cnt_base_s;

   // clr and en may coincide: the first bit of a frame lands on a fresh history
   always_comb begin
      hist_base_s = clr_i ? 2'b00 : hist_q;
      cnt_base_s  = clr_i ? {CNT_W{1'b0}} : cnt_q;
      hist_d      = hist_base_s;
      cnt_d       = cnt_base_s;
      if (en_i) begin
         hist_d = {hist_base_s[0], bit_i};
         if ((hist_base_s == 2'b10) && bit_i) begin
            cnt_d = cnt_base_s + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            cnt_d = cnt_base_s;
         end
      end else begin
         hist_d = hist_base_s;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hist_q <= 2'b00;
         cnt_q  <= {CNT_W{1'b0}};
      end else begin
         hist_q <= hist_d;
         cnt_q  <= cnt_d;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/pattern_serializer_101.sv
// Serializes a WIDTH-bit word MSB first on a registered bit stream and predicts
// how many overlapping "101" patterns a downstream detector will see.
module pattern_serializer_101
   import pattern_serializer_101_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic             x,
   output logic             bit_valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] exp_cnt
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [4:0]       bitcnt_q, bitcnt_d;
   logic             x_q, x_d;
   logic             bv_q, bv_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             trk_clr_s, trk_en_s, trk_bit_s;

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bitcnt_d  = bitcnt_q;
      x_d       = 1'b0;
      bv_d      = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      trk_clr_s = 1'b0;
      trk_en_s  = 1'b0;
      trk_bit_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               x_d       = din[WIDTH-1];
               bv_d      = 1'b1;
               busy_d    = 1'b1;
               shreg_d   = {din[WIDTH-2:0], 1'b0};
               bitcnt_d  = 5'(WIDTH - 1);
               trk_clr_s = 1'b1;
               trk_en_s  = 1'b1;
               trk_bit_s = din[WIDTH-1];
               state_d   = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            busy_d = 1'b1;
            if (bitcnt_q != 5'd0) begin
               x_d       = shreg_q[WIDTH-1];
               bv_d      = 1'b1;
               shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
               bitcnt_d  = bitcnt_q - 5'd1;
               trk_en_s  = 1'b1;
               trk_bit_s = shreg_q[WIDTH-1];
            end else begin
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         shreg_q  <= {WIDTH{1'b0}};
         bitcnt_q <= 5'd0;
         x_q      <= 1'b0;
         bv_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         x_q      <= x_d;
         bv_q     <= bv_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   match101_tracker u_tracker (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (trk_clr_s),
      .en_i    (trk_en_s),
      .bit_i   (trk_bit_s),
      .count_o (exp_cnt)
   );

   assign x         = x_q;
   assign bit_valid = bv_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_pattern_serializer_101.sv
// Directed bench for pattern_serializer_101 with a frame-timing reference model
// checked every cycle, plus literal expectations for selected frames.
module tb_pattern_serializer_101;
   import pattern_serializer_101_pkg::*;

   localparam int W = DEFAULT_WIDTH;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] din = '0;
   logic         x, bit_valid, busy, done;
   logic [4:0]   exp_cnt;

   int checks = 0;
   int errors = 0;

   pattern_serializer_101 #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .load(load), .din(din),
      .x(x), .bit_valid(bit_valid), .busy(busy), .done(done), .exp_cnt(exp_cnt)
   );

   always #5 clk = ~clk;

   // reference: frame accepted at edge s puts bit j on x after edge s+j
   int           ecnt = 0;
   int           s_m = 0;
   bit           have_m = 1'b0;
   bit           model_on = 1'b0;
   logic [W-1:0] word_m = '0;

   function automatic int c101(input logic [W-1:0] w, input int n);
      int c = 0;
      for (int k = 2; k < n; k++)
         if (w[W-1-(k-2)] && !w[W-1-(k-1)] && w[W-1-k]) c++;
      return c;
   endfunction

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
      end
   endtask

   always @(posedge clk) begin
      ecnt <= ecnt + 1;
      if (rst) begin
         have_m   <= 1'b0;
         model_on <= 1'b1;
      end else if (load && (!have_m || ecnt >= s_m + W + 2)) begin
         have_m <= 1'b1;
         s_m    <= ecnt;
         word_m <= din;
      end
   end

   // per-cycle comparison against the reference
   always @(negedge clk) begin
      int j, ex, ebv, ebusy, edone, ecn;
      if (model_on) begin
         j = ecnt - 1 - s_m;
         ex = 0; ebv = 0; ebusy = 0; edone = 0; ecn = 0;
         if (have_m) begin
            if (j < W) begin
               ex = int'(word_m[W-1-j]); ebv = 1; ebusy = 1; ecn = c101(word_m, j + 1);
            end else if (j == W) begin
               ebusy = 1; edone = 1; ecn = c101(word_m, W);
            end else begin
               ecn = c101(word_m, W);
            end
         end
         chk("x", int'(x), ex);
         chk("bit_valid", int'(bit_valid), ebv);
         chk("busy", int'(busy), ebusy);
         chk("done", int'(done), edone);
         chk("exp_cnt", int'(exp_cnt), ecn);
      end
   end

   task automatic wait_idle();
      int t = 0;
      while (busy !== 1'b0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("idle_timeout", t < 20 ? 1 : 0, 1);
   endtask

   task automatic run_frame(input logic [W-1:0] w, input int lit_cnt);
      logic [W-1:0] cap;
      wait_idle();
      load = 1'b1;
      din  = w;
      @(negedge clk);
      load = 1'b0;
      din  = ~w;
      for (int k = 0; k < W; k++) begin
         cap[W-1-k] = x;
         if (k < W - 1) @(negedge clk);
      end
      @(negedge clk);
      chk("frame_stream", int'(cap), int'(w));
      chk("frame_done", int'(done), 1);
      chk("frame_cnt", int'(exp_cnt), lit_cnt);
   endtask

   initial begin
      logic [W-1:0] cap;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_x", int'(x), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cnt", int'(exp_cnt), 0);
      rst = 1'b0;

      run_frame(8'b10101010, 3);
      run_frame(8'b11011011, 2);
      run_frame(8'h00, 0);
      run_frame(8'hFF, 0);

      // load held high with din changing mid-frame
      wait_idle();
      load = 1'b1;
      din  = 8'hA5;
      @(negedge clk);
      for (int k = 0; k < W; k++) begin
         cap[W-1-k] = x;
         if (k == 2) din = 8'h3C;
         @(negedge clk);
      end
      chk("held_stream", int'(cap), 32'hA5);
      chk("held_done", int'(done), 1);
      chk("held_cnt", int'(exp_cnt), 2);
      @(negedge clk);
      chk("held_gap_busy", int'(busy), 0);
      @(negedge clk);
      chk("held_restart_busy", int'(busy), 1);
      chk("held_restart_bv", int'(bit_valid), 1);
      load = 1'b0;

      // reset after the 4th bit aborts the frame
      wait_idle();
      load = 1'b1;
      din  = 8'b10110101;
      @(negedge clk);
      load = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_abort_cnt", int'(exp_cnt), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_x", int'(x), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_cnt", int'(exp_cnt), 0);
      rst  = 1'b0;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("after_rst_accept", int'(bit_valid), 1);
      repeat (W) @(negedge clk);
      chk("after_rst_done", int'(done), 1);
      chk("after_rst_cnt", int'(exp_cnt), 3);

      run_frame(8'b00000010, 0);
      run_frame(8'b10000000, 0);

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pattern_serializer_101.md
PATTERN_SERIALIZER_101 -- requirements
Module: pattern_serializer_101

Interface
REQ-001 Parameter: WIDTH, default 8, frame length in bits (legal range 3..16).
REQ-002 Port: clk  input  1  single clock, all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: load  input  1  request to start a frame; sampled only in IDLE.
REQ-005 Port: din  input  WIDTH  frame word, transmitted MSB first.
REQ-006 Port: x  output  1  registered serial bit stream, drives the 101 detector input.
REQ-007 Port: bit_valid  output  1  high while x carries a frame bit.
REQ-008 Port: busy  output  1  high in SHIFT and DONE states.
REQ-009 Port: done  output  1  one-cycle pulse after the last bit.
REQ-010 Port: exp_cnt  output  5  predicted count of overlapping "101" occurrences in the current or last frame.

Function
REQ-011 States: IDLE, SHIFT, DONE; all outputs registered, no combinational path from inputs to outputs.
REQ-012 IDLE with load=1 at an edge:
- x<=din[WIDTH-1], bit_valid<=1, shreg<=din<<1, bitcnt<=WIDTH-1, exp_cnt<=0, history cleared, state<=SHIFT.
REQ-013 SHIFT with bitcnt!=0 at an edge:
- x<=shreg[WIDTH-1], shreg shifts left by one, bitcnt decrements.
- Frame bit k (k=0 MSB) is therefore on x during cycle k after the load edge; WIDTH bits on consecutive cycles, no gaps.
REQ-014 SHIFT with bitcnt==0 at an edge:
- x<=0, bit_valid<=0, done<=1, state<=DONE.
REQ-015 DONE: at the next edge done<=0 and state<=IDLE; DONE always lasts exactly one cycle.
REQ-016 load is ignored in SHIFT and DONE (no queuing); a new frame starts at the earliest on the edge after DONE exits, so frames are separated by at least two idle cycles.
REQ-017 In IDLE and DONE: x=0 and bit_valid=0; din is don't-care outside the load edge.
REQ-018 Match prediction:
- Track the last two emitted bits (h1 older, h0 newer) of the current frame.
- On each edge that emits bit b with h1=1, h0=0, b=1, exp_cnt increments in the same edge.
- Overlap is allowed (10101 counts 2); history never spans frames.
REQ-019 exp_cnt holds its final value through DONE and IDLE until the next accepted load; max value WIDTH-2 fits 5 bits, no wrap.

Reset
REQ-020 rst=1 at an edge forces state=IDLE, x=0, bit_valid=0, busy=0, done=0, exp_cnt=0, shreg=0, bitcnt=0, history=00; rst takes priority over load.
REQ-021 rst mid-frame aborts the frame with no done pulse; load in the first cycle after rst deassertion is accepted.

Structure
REQ-022 A shared package holds the state enum (IDLE/SHIFT/DONE) and the default WIDTH constant; the detector testbench imports the same package.
REQ-023 One sub-module, match101_tracker (inputs clk, rst, clr, en, bit; output count), implements REQ-018; all other logic stays in the top.

Verification
REQ-024 rst=1 for 2 cycles then load=1, din=8'b10101010 -> x=1,0,1,0,1,0,1,0 on cycles 1..8 after load edge, bit_valid high for those 8 cycles, done pulse on cycle 9, exp_cnt=3.
REQ-025 load din=8'b11011011 -> x=1,1,0,1,1,0,1,1, exp_cnt=2; the external 101 detector z pulses exactly twice.
REQ-026 load din=8'h00, then din=8'hFF in the next frame -> exp_cnt=0 both times, x all-0 then all-1.
REQ-027 load=1 held on every cycle, din changed mid-frame -> first din serialized unchanged, next frame starts the cycle after DONE exits.
REQ-028 rst=1 asserted after the 4th bit of 8'b10110101 -> next cycle x=0, busy=0, exp_cnt=0, no done pulse; a fresh load immediately after completes normally.
REQ-029 Frame 8'b00000010 followed by 8'b10000000 -> exp_cnt=0 for the second frame (no cross-frame match).
